axilite_master: RTL and testbench
=================================

# axilite_master

AXI4-Lite initiator that converts a simple req/ack command interface into AXI4-Lite write and read transactions. It is the opposite end of `axilite_slave` and is used by in-fabric engines and testbenches to drive register/memory slaves. Write and read engines are independent, so one write and one read may be outstanding at the same time. Each engine has a single outstanding transaction.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 64, data width; must be a multiple of 8
- TIMEOUT_W, 8, width of the response watchdog counter; used only with AXILITE_MASTER_TIMEOUT_EN

Ports:
- aclk  in  1  the only clock
- areset  in  1  reset, synchronous, active-high
- usr_w_req  in  1  write request (level); addr, data and strb must be stable while it is high
- usr_w_addr  in  ADDR_W  write address
- usr_w_data  in  DATA_W  write data
- usr_w_strb  in  DATA_W/8  byte strobes
- usr_w_ack  out  1  one-cycle completion pulse
- usr_w_resp  out  2  captured BRESP; valid while usr_w_ack=1
- usr_r_req  in  1  read request (level)
- usr_r_addr  in  ADDR_W  read address
- usr_r_ack  out  1  one-cycle completion pulse
- usr_r_data  out  DATA_W  captured RDATA; valid while usr_r_ack=1
- usr_r_resp  out  2  captured RRESP
- m_axi_awaddr/awvalid/awready  out/out/in  ADDR_W/1/1
- m_axi_wdata/wstrb/wvalid/wready  out/out/out/in  DATA_W/DATA_W/8/1/1
- m_axi_bresp/bvalid/bready  in/in/out  2/1/1
- m_axi_araddr/arvalid/arready  out/out/in  ADDR_W/1/1
- m_axi_rdata/rresp/rvalid/rready  in/in/in/out  DATA_W/2/1/1

## Operation

**Write FSM: W_IDLE -> W_SEND -> W_RESP -> W_IDLE**
- W_IDLE: if usr_w_req=1 and usr_w_ack=0:
  - register addr, data and strb onto awaddr, wdata and wstrb;
  - set awvalid=1 and wvalid=1;
  - go to W_SEND.
- W_SEND: awvalid and wvalid are tracked independently.
  - Each valid clears on its own handshake (valid & ready sampled high).
  - When both handshakes have completed (in the same or different cycles), go to W_RESP with bready=1.
- W_RESP: on bvalid & bready:
  - capture bresp into usr_w_resp;
  - drop bready;
  - pulse usr_w_ack;
  - go to W_IDLE.

**Read FSM: R_IDLE -> R_ADDR -> R_DATA -> R_IDLE**
- R_IDLE: if usr_r_req=1 and usr_r_ack=0, register araddr, set arvalid=1, go to R_ADDR.
- R_ADDR: on arready, clear arvalid, set rready=1, go to R_DATA.
- R_DATA: on rvalid, capture rdata and rresp, clear rready, pulse usr_r_ack, go to R_IDLE.

**AXI rules**
- A valid, once asserted, stays asserted with constant payload until its handshake.
- No valid depends combinationally on a ready.
- All AXI and usr outputs are registered.
- bready is high only in W_RESP; rready is high only in R_DATA.

**Back-to-back requests**
- A request still high in the cycle where its ack is high is NOT taken again.
- A request high on the cycle after the ack is treated as a new transaction.

**Reset**
- All outputs reset to 0: valids, readies, acks, resp, rdata, awaddr, araddr, wdata, wstrb.
- Both FSMs reset to IDLE.
- Reset mid-transaction abandons it: valids and readies are 0 on the cycle after areset is sampled, and no ack is issued.

## Timing
- Write, zero-wait slave:
  - req sampled in cycle 0;
  - awvalid and wvalid high in cycle 1, with awready and wready also high;
  - bready high in cycle 2, with bvalid;
  - usr_w_ack in cycle 3.
  - Minimum latency is 3 cycles from req to ack.
- Read, zero-wait slave:
  - req in cycle 0;
  - arvalid in cycle 1;
  - rready in cycle 2, with rvalid;
  - usr_r_ack in cycle 3.
- Every cycle of slave stall (ready or valid low) adds exactly one cycle.
- Minimum write throughput is one transaction per 4 cycles; the same holds for reads.
- A simultaneous read and write complete independently; one channel never stalls the other.

## Configuration
- AXILITE_MASTER_TIMEOUT_EN defined:
  - Each FSM has a TIMEOUT_W-bit counter.
  - The counter clears on entering SEND/ADDR and increments every cycle spent in SEND/ADDR/RESP/DATA.
  - When it reaches 2^TIMEOUT_W-1, the FSM:
    - deasserts all its valids and readies;
    - pulses its ack with resp=2'b11 (usr_r_data=0);
    - returns to IDLE.
- Not defined:
  - The counter logic is absent and the FSMs wait indefinitely.
  - TIMEOUT_W is unused.

## Test plan
- Zero-wait write: addr=0x10000008, data=0xDEADBEEF_CAFEF00D, strb=0xFF.
  - Required: awvalid and wvalid in cycle 1 with that payload, usr_w_ack in cycle 3, usr_w_resp=0.
- Skewed write: wready delayed 4 cycles after awready.
  - Required: awvalid drops after its handshake, wvalid holds with data unchanged, then a single usr_w_ack; no duplicate AW beat.
- Read with rvalid delayed 5 cycles and slave returning rdata=0x0123456789ABCDEF, rresp=2'b10.
  - Required: usr_r_ack once, in the cycle after rvalid, with usr_r_data=0x0123456789ABCDEF and usr_r_resp=2'b10.
- Concurrent write and read issued in the same cycle with a zero-wait slave.
  - Required: both acks in cycle 3.
- req held high through its ack.
  - Required: no transaction is issued in the ack cycle; a second transaction starts on the following cycle.
- Timeout and reset (TIMEOUT_W=4, macro defined):
  - Slave never asserts bvalid -> usr_w_ack with resp=2'b11 after 15 cycles.
  - Separately, areset asserted while in W_SEND -> all valids 0 the next cycle, no ack.

Source files
------------

// File: rtl/axilite_master.sv
// rtl/axilite_master.sv - AXI4-Lite initiator bridging req/ack commands to independent write and read engines.
// Optional response watchdog enabled by defining AXILITE_MASTER_TIMEOUT_EN.
module axilite_master #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64,
  parameter int TIMEOUT_W = 8
) (
  input  logic                  aclk,
  input  logic                  areset,

  input  logic                  usr_w_req,
  input  logic [ADDR_W-1:0]     usr_w_addr,
  input  logic [DATA_W-1:0]     usr_w_data,
  input  logic [DATA_W/8-1:0]   usr_w_strb,
  output logic                  usr_w_ack,
  output logic [1:0]            usr_w_resp,

  input  logic                  usr_r_req,
  input  logic [ADDR_W-1:0]     usr_r_addr,
  output logic                  usr_r_ack,
  output logic [DATA_W-1:0]     usr_r_data,
  output logic [1:0]            usr_r_resp,

  output logic [ADDR_W-1:0]     m_axi_awaddr,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_W-1:0]     m_axi_wdata,
  output logic [DATA_W/8-1:0]   m_axi_wstrb,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,

  output logic [ADDR_W-1:0]     m_axi_araddr,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DATA_W-1:0]     m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  localparam int STRB_W = DATA_W / 8;

  if ((DATA_W % 8) != 0 || TIMEOUT_W < 1) begin : g_bad_param
    $error("axilite_master: DATA_W must be a multiple of 8 and TIMEOUT_W at least 1");
  end

  typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_e;

  // ---------------- write engine state ----------------
  w_state_e              w_state_q, w_state_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  bready_q, bready_d;
  logic [ADDR_W-1:0]     awaddr_q, awaddr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [STRB_W-1:0]     wstrb_q, wstrb_d;
  logic                  w_ack_q, w_ack_d;
  logic [1:0]            w_resp_q, w_resp_d;

  // ---------------- read engine state ----------------
  r_state_e              r_state_q, r_state_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q, rready_d;
  logic [ADDR_W-1:0]     araddr_q, araddr_d;
  logic                  r_ack_q, r_ack_d;
  logic [DATA_W-1:0]     r_data_q, r_data_d;
  logic [1:0]            r_resp_q, r_resp_d;

`ifdef AXILITE_MASTER_TIMEOUT_EN
  logic [TIMEOUT_W-1:0]  w_cnt_q, w_cnt_d;
  logic [TIMEOUT_W-1:0]  r_cnt_q, r_cnt_d;
`endif

  // Write engine: AW and W valids retire independently; B is awaited only after both.
  always_comb begin
    w_state_d = w_state_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    w_ack_d   = 1'b0;
    w_resp_d  = w_resp_q;
`ifdef AXILITE_MASTER_TIMEOUT_EN
    w_cnt_d   = w_cnt_q;
`endif
    case (w_state_q)
      W_IDLE: begin
        if (usr_w_req && !w_ack_q) begin
          awaddr_d  = usr_w_addr;
          wdata_d   = usr_w_data;
          wstrb_d   = usr_w_strb;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          w_state_d = W_SEND;
`ifdef AXILITE_MASTER_TIMEOUT_EN
          w_cnt_d   = '0;
`endif
        end
      end
      W_SEND: begin
        awvalid_d = awvalid_q & ~m_axi_awready;
        wvalid_d  = wvalid_q & ~m_axi_wready;
        if (!awvalid_d && !wvalid_d) begin
          bready_d  = 1'b1;
          w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (m_axi_bvalid) begin
          w_resp_d  = m_axi_bresp;
          bready_d  = 1'b0;
          w_ack_d   = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: begin
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        bready_d  = 1'b0;
        w_state_d = W_IDLE;
      end
    endcase
`ifdef AXILITE_MASTER_TIMEOUT_EN
    if (w_state_q != W_IDLE) begin
      w_cnt_d = w_cnt_q + TIMEOUT_W'(1);
      // A real response arriving in the expiry cycle still wins over the watchdog.
      if ((w_cnt_q == {TIMEOUT_W{1'b1}}) && !w_ack_d) begin
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        bready_d  = 1'b0;
        w_ack_d   = 1'b1;
        w_resp_d  = 2'b11;
        w_state_d = W_IDLE;
      end
    end
`endif
  end

  // Read engine: AR handshake, then wait for a single R beat.
  always_comb begin
    r_state_d = r_state_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    araddr_d  = araddr_q;
    r_ack_d   = 1'b0;
    r_data_d  = r_data_q;
    r_resp_d  = r_resp_q;
`ifdef AXILITE_MASTER_TIMEOUT_EN
    r_cnt_d   = r_cnt_q;
`endif
    case (r_state_q)
      R_IDLE: begin
        if (usr_r_req && !r_ack_q) begin
          araddr_d  = usr_r_addr;
          arvalid_d = 1'b1;
          r_state_d = R_ADDR;
`ifdef AXILITE_MASTER_TIMEOUT_EN
          r_cnt_d   = '0;
`endif
        end
      end
      R_ADDR: begin
        if (m_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (m_axi_rvalid) begin
          r_data_d  = m_axi_rdata;
          r_resp_d  = m_axi_rresp;
          rready_d  = 1'b0;
          r_ack_d   = 1'b1;
          r_state_d = R_IDLE;
        end
      end
      default: begin
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
        r_state_d = R_IDLE;
      end
    endcase
`ifdef AXILITE_MASTER_TIMEOUT_EN
    if (r_state_q != R_IDLE) begin
      r_cnt_d = r_cnt_q + TIMEOUT_W'(1);
      if ((r_cnt_q == {TIMEOUT_W{1'b1}}) && !r_ack_d) begin
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
        r_ack_d   = 1'b1;
        r_data_d  = '0;
        r_resp_d  = 2'b11;
        r_state_d = R_IDLE;
      end
    end
`endif
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      w_state_q <= W_IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      w_ack_q   <= 1'b0;
      w_resp_q  <= 2'b00;
      r_state_q <= R_IDLE;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      araddr_q  <= '0;
      r_ack_q   <= 1'b0;
      r_data_q  <= '0;
      r_resp_q  <= 2'b00;
`ifdef AXILITE_MASTER_TIMEOUT_EN
      w_cnt_q   <= '0;
      r_cnt_q   <= '0;
`endif
    end else begin
      w_state_q <= w_state_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      w_ack_q   <= w_ack_d;
      w_resp_q  <= w_resp_d;
      r_state_q <= r_state_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      araddr_q  <= araddr_d;
      r_ack_q   <= r_ack_d;
      r_data_q  <= r_data_d;
      r_resp_q  <= r_resp_d;
`ifdef AXILITE_MASTER_TIMEOUT_EN
      w_cnt_q   <= w_cnt_d;
      r_cnt_q   <= r_cnt_d;
`endif
    end
  end

  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;
  assign usr_w_ack     = w_ack_q;
  assign usr_w_resp    = w_resp_q;
  assign usr_r_ack     = r_ack_q;
  assign usr_r_data    = r_data_q;
  assign usr_r_resp    = r_resp_q;

endmodule

// File: tb/tb_axilite_master.sv
// tb/tb_axilite_master.sv - directed bench for axilite_master.
module tb_axilite_master;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;

  logic              aclk = 1'b0;
  logic              areset;
  logic              usr_w_req;
  logic [ADDR_W-1:0] usr_w_addr;
  logic [DATA_W-1:0] usr_w_data;
  logic [7:0]        usr_w_strb;
  logic              usr_w_ack;
  logic [1:0]        usr_w_resp;
  logic              usr_r_req;
  logic [ADDR_W-1:0] usr_r_addr;
  logic              usr_r_ack;
  logic [DATA_W-1:0] usr_r_data;
  logic [1:0]        usr_r_resp;
  logic [ADDR_W-1:0] m_axi_awaddr;
  logic              m_axi_awvalid, m_axi_awready;
  logic [DATA_W-1:0] m_axi_wdata;
  logic [7:0]        m_axi_wstrb;
  logic              m_axi_wvalid, m_axi_wready;
  logic [1:0]        m_axi_bresp;
  logic              m_axi_bvalid, m_axi_bready;
  logic [ADDR_W-1:0] m_axi_araddr;
  logic              m_axi_arvalid, m_axi_arready;
  logic [DATA_W-1:0] m_axi_rdata;
  logic [1:0]        m_axi_rresp;
  logic              m_axi_rvalid, m_axi_rready;

  always #5 aclk = ~aclk;

  axilite_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_W(4)) dut (
    .aclk(aclk), .areset(areset),
    .usr_w_req(usr_w_req), .usr_w_addr(usr_w_addr), .usr_w_data(usr_w_data),
    .usr_w_strb(usr_w_strb), .usr_w_ack(usr_w_ack), .usr_w_resp(usr_w_resp),
    .usr_r_req(usr_r_req), .usr_r_addr(usr_r_addr), .usr_r_ack(usr_r_ack),
    .usr_r_data(usr_r_data), .usr_r_resp(usr_r_resp),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  int n_checks = 0;
  int n_errors = 0;
  int aw_hs = 0, w_hs = 0, ar_hs = 0, w_acks = 0, r_acks = 0;

  always @(posedge aclk) begin
    if (!areset) begin
      if (m_axi_awvalid && m_axi_awready) aw_hs++;
      if (m_axi_wvalid && m_axi_wready) w_hs++;
      if (m_axi_arvalid && m_axi_arready) ar_hs++;
      if (usr_w_ack) w_acks++;
      if (usr_r_ack) r_acks++;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge aclk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int base_aw, base_ack, base_rack, lat;
  logic found;

  initial begin
    areset = 1'b1;
    usr_w_req = 0; usr_w_addr = '0; usr_w_data = '0; usr_w_strb = '0;
    usr_r_req = 0; usr_r_addr = '0;
    m_axi_awready = 0; m_axi_wready = 0; m_axi_bresp = 0; m_axi_bvalid = 0;
    m_axi_arready = 0; m_axi_rdata = '0; m_axi_rresp = 0; m_axi_rvalid = 0;
    cyc(3);
    check_eq("rst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready}, 64'h0);
    check_eq("rst_acks", {usr_w_ack, usr_r_ack, usr_w_resp, usr_r_resp}, 64'h0);
    check_eq("rst_addr", {m_axi_awaddr, m_axi_araddr}, 64'h0);
    check_eq("rst_data", m_axi_wdata | usr_r_data | {56'h0, m_axi_wstrb}, 64'h0);
    areset = 1'b0;
    cyc(1);

    // zero-wait write
    usr_w_req = 1; usr_w_addr = 32'h1000_0008; usr_w_data = 64'hDEAD_BEEF_CAFE_F00D; usr_w_strb = 8'hFF;
    cyc(1);
    check_eq("zw_c1_valids", {m_axi_awvalid, m_axi_wvalid}, 64'h3);
    check_eq("zw_c1_awaddr", m_axi_awaddr, 64'h1000_0008);
    check_eq("zw_c1_wdata", m_axi_wdata, 64'hDEAD_BEEF_CAFE_F00D);
    check_eq("zw_c1_wstrb", m_axi_wstrb, 64'hFF);
    usr_w_req = 0; m_axi_awready = 1; m_axi_wready = 1;
    cyc(1);
    check_eq("zw_c2", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, usr_w_ack}, 64'h2);
    m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 1; m_axi_bresp = 2'b00;
    cyc(1);
    check_eq("zw_c3_ack", {usr_w_ack, m_axi_bready}, 64'h2);
    check_eq("zw_c3_resp", usr_w_resp, 64'h0);
    m_axi_bvalid = 0;
    cyc(1);
    check_eq("zw_c4_ack", usr_w_ack, 64'h0);
    check_eq("zw_aw_count", aw_hs, 64'd1);

    // skewed write: wready 4 cycles after awready
    base_aw = aw_hs; base_ack = w_acks;
    usr_w_req = 1; usr_w_addr = 32'h2000_0040; usr_w_data = 64'h1111_2222_3333_4444; usr_w_strb = 8'h0F;
    cyc(1);
    check_eq("sk_c1_valids", {m_axi_awvalid, m_axi_wvalid}, 64'h3);
    m_axi_awready = 1;
    cyc(1);
    usr_w_req = 0; m_axi_awready = 0;
    check_eq("sk_c2_valids", {m_axi_awvalid, m_axi_wvalid}, 64'h1);
    for (int k = 3; k <= 5; k++) begin
      cyc(1);
      check_eq($sformatf("sk_c%0d_hold", k), {m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 64'h2);
      check_eq($sformatf("sk_c%0d_wdata", k), m_axi_wdata, 64'h1111_2222_3333_4444);
    end
    m_axi_wready = 1;
    cyc(1);
    check_eq("sk_c6", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, usr_w_ack}, 64'h2);
    m_axi_wready = 0; m_axi_bvalid = 1; m_axi_bresp = 2'b01;
    cyc(1);
    check_eq("sk_c7_ack", usr_w_ack, 64'h1);
    check_eq("sk_c7_resp", usr_w_resp, 64'h1);
    m_axi_bvalid = 0;
    cyc(2);
    check_eq("sk_aw_beats", aw_hs - base_aw, 64'd1);
    check_eq("sk_ack_count", w_acks - base_ack, 64'd1);

    // read with rvalid 5 cycles after rready
    base_rack = r_acks;
    usr_r_req = 1; usr_r_addr = 32'h3000_0100;
    cyc(1);
    check_eq("rd_c1_arvalid", m_axi_arvalid, 64'h1);
    check_eq("rd_c1_araddr", m_axi_araddr, 64'h3000_0100);
    usr_r_req = 0; m_axi_arready = 1;
    cyc(1);
    check_eq("rd_c2", {m_axi_arvalid, m_axi_rready}, 64'h1);
    m_axi_arready = 0;
    for (int k = 3; k <= 7; k++) begin
      cyc(1);
      check_eq($sformatf("rd_c%0d_wait", k), {m_axi_rready, usr_r_ack}, 64'h2);
    end
    m_axi_rvalid = 1; m_axi_rdata = 64'h0123_4567_89AB_CDEF; m_axi_rresp = 2'b10;
    cyc(1);
    check_eq("rd_c8_ack", {usr_r_ack, m_axi_rready}, 64'h2);
    check_eq("rd_c8_data", usr_r_data, 64'h0123_4567_89AB_CDEF);
    check_eq("rd_c8_resp", usr_r_resp, 64'h2);
    m_axi_rvalid = 0; m_axi_rdata = '0; m_axi_rresp = 0;
    cyc(1);
    check_eq("rd_c9_ack", usr_r_ack, 64'h0);
    check_eq("rd_ack_count", r_acks - base_rack, 64'd1);

    // concurrent write and read, zero-wait
    usr_w_req = 1; usr_w_addr = 32'h0000_0010; usr_w_data = 64'h55; usr_w_strb = 8'h01;
    usr_r_req = 1; usr_r_addr = 32'h0000_0020;
    cyc(1);
    check_eq("cc_c1_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}, 64'h7);
    usr_w_req = 0; usr_r_req = 0;
    m_axi_awready = 1; m_axi_wready = 1; m_axi_arready = 1;
    cyc(1);
    check_eq("cc_c2_readies", {m_axi_bready, m_axi_rready}, 64'h3);
    m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
    m_axi_bvalid = 1; m_axi_bresp = 0; m_axi_rvalid = 1; m_axi_rdata = 64'hA5A5_0000_FFFF_5A5A;
    cyc(1);
    check_eq("cc_c3_acks", {usr_w_ack, usr_r_ack}, 64'h3);
    check_eq("cc_c3_rdata", usr_r_data, 64'hA5A5_0000_FFFF_5A5A);
    m_axi_bvalid = 0; m_axi_rvalid = 0; m_axi_rdata = '0;
    cyc(1);

    // request held high through its ack
    usr_w_req = 1; usr_w_addr = 32'h0000_0100; usr_w_data = 64'h77; usr_w_strb = 8'h80;
    cyc(1);
    m_axi_awready = 1; m_axi_wready = 1;
    cyc(1);
    m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 1;
    cyc(1);
    check_eq("hold_c3_ack", usr_w_ack, 64'h1);
    m_axi_bvalid = 0;
    cyc(1);
    check_eq("hold_c4_idle", {m_axi_awvalid, m_axi_wvalid, usr_w_ack}, 64'h0);
    cyc(1);
    check_eq("hold_c5_new", {m_axi_awvalid, m_axi_wvalid}, 64'h3);
    usr_w_req = 0; m_axi_awready = 1; m_axi_wready = 1;
    cyc(1);
    m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 1;
    cyc(1);
    check_eq("hold_c7_ack", usr_w_ack, 64'h1);
    m_axi_bvalid = 0;
    cyc(1);

    // reset while both engines are mid-transaction
    usr_w_req = 1; usr_r_req = 1; usr_w_addr = 32'h4; usr_r_addr = 32'h8;
    cyc(1);
    check_eq("rst_mid_c1", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}, 64'h7);
    usr_w_req = 0; usr_r_req = 0; areset = 1;
    cyc(1);
    check_eq("rst_mid_c2", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready}, 64'h0);
    areset = 0;
    base_ack = w_acks; base_rack = r_acks;
    for (int k = 0; k < 3; k++) begin
      cyc(1);
      check_eq($sformatf("rst_mid_noack%0d", k), {usr_w_ack, usr_r_ack, m_axi_awvalid, m_axi_arvalid}, 64'h0);
    end
    check_eq("rst_mid_ackcnt", (w_acks - base_ack) + (r_acks - base_rack), 64'd0);

`ifdef AXILITE_MASTER_TIMEOUT_EN
    // bvalid never arrives: counter 0 in cycle 1 reaches 15 in cycle 16, ack in cycle 17
    usr_w_req = 1; usr_w_addr = 32'hC; usr_w_data = 64'h1; usr_w_strb = 8'h1;
    cyc(1);
    usr_w_req = 0; m_axi_awready = 1; m_axi_wready = 1;
    lat = 1; found = 1'b0;
    while (!found && lat < 40) begin
      cyc(1);
      lat++;
      m_axi_awready = 0; m_axi_wready = 0;
      if (usr_w_ack) found = 1'b1;
    end
    check_eq("to_ack_seen", found, 64'h1);
    check_eq("to_latency", lat, 64'd17);
    check_eq("to_resp", usr_w_resp, 64'h3);
    check_eq("to_bready", m_axi_bready, 64'h0);
    cyc(1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
